// File: rtl/downcounter_pkg.sv
// ----------------------------------------------------------------------------
// downcounter_pkg
// Shared definitions for the down-counting timer:
//   DEFAULT_WIDTH : default counter width in bits
//   state_t       : FSM state encoding (IDLE=0, RUN=1, PAUSE=2, DONE=3)
//   dp_op_t       : command from the FSM to the datapath for the next edge
// ----------------------------------------------------------------------------
package downcounter_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        DP_HOLD   = 2'd0,
        DP_LOAD   = 2'd1,
        DP_DEC    = 2'd2,
        DP_RELOAD = 2'd3
    } dp_op_t;

endpackage : downcounter_pkg

// File: rtl/dc_datapath.sv
// ----------------------------------------------------------------------------
// dc_datapath
// Count register and reload register with the decrement/reload mux.
// The FSM in the top level decides what happens on each edge via i_op.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   i_op             : HOLD / LOAD (q and rld from i_load_val) / DEC / RELOAD
//   i_load_val       : value captured on LOAD
//   o_q, o_rld       : current count and reload value
//   o_q_is_one       : count is about to reach its terminal value
//   o_q_is_zero      : count is zero
//   o_rld_is_zero    : reload value is zero (reload not possible)
// ----------------------------------------------------------------------------
module dc_datapath
    import downcounter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  dp_op_t           i_op,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_rld,
    output logic             o_q_is_one,
    output logic             o_q_is_zero,
    output logic             o_rld_is_zero
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_rld;

    // Count and reload registers. The decrement wraps modulo 2^WIDTH, but
    // the FSM never issues DEC while the count is zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q   <= '0;
            r_rld <= '0;
        end else begin
            case (i_op)
                DP_LOAD: begin
                    r_q   <= i_load_val;
                    r_rld <= i_load_val;
                end
                DP_DEC:    r_q <= r_q - WIDTH'(1);
                DP_RELOAD: r_q <= r_rld;
                default:   r_q <= r_q;
            endcase
        end
    end

    assign o_q           = r_q;
    assign o_rld         = r_rld;
    assign o_q_is_one    = (r_q == WIDTH'(1));
    assign o_q_is_zero   = (r_q == '0);
    assign o_rld_is_zero = (r_rld == '0);

endmodule : dc_datapath

// File: rtl/downcounter_timer.sv
// ----------------------------------------------------------------------------
// downcounter_timer
// Loadable down-counting timer with start/stop control, optional periodic
// auto-reload and a one-cycle terminal-count pulse.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   load         : load load_val into count and reload register (highest priority)
//   load_val     : value to load
//   start, stop  : start/resume and pause; stop wins when both are high
//   auto_reload  : periodic mode, count restarts from the reload value
//   q            : registered current count
//   tc           : registered terminal-count pulse, one cycle wide
//   busy         : high in RUN or PAUSE
//   state        : current FSM state
// ----------------------------------------------------------------------------
module downcounter_timer
    import downcounter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             busy,
    output logic [1:0]       state
);

    state_t           r_state;
    logic             r_tc;
    state_t           w_next_state;
    dp_op_t           w_op;
    logic             w_tc_next;
    logic             w_go;
    logic             w_q_is_one;
    logic             w_q_is_zero;
    logic             w_rld_is_zero;
    logic [WIDTH-1:0] w_rld;

    dc_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_op         (w_op),
        .i_load_val   (load_val),
        .o_q          (q),
        .o_rld        (w_rld),
        .o_q_is_one   (w_q_is_one),
        .o_q_is_zero  (w_q_is_zero),
        .o_rld_is_zero(w_rld_is_zero)
    );

    // start only counts as a request when stop is not also asserted
    assign w_go = start && !stop;

    // State and terminal-count registers; reset drops any pending pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_tc    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_tc    <= w_tc_next;
        end
    end

    // Next-state, datapath command and tc decode. In RUN with q==1, a
    // reload is only possible when rld is non-zero; otherwise the count
    // finishes in DONE exactly as in one-shot mode.
    always_comb begin
        w_next_state = r_state;
        w_op         = DP_HOLD;
        w_tc_next    = 1'b0;
        if (load) begin
            w_op         = DP_LOAD;
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_go && !w_q_is_zero) begin
                        w_next_state = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        w_next_state = ST_PAUSE;
                    end else if (w_q_is_one) begin
                        w_tc_next = 1'b1;
                        if (auto_reload && !w_rld_is_zero) begin
                            w_op = DP_RELOAD;
                        end else begin
                            w_op         = DP_DEC;
                            w_next_state = ST_DONE;
                        end
                    end else begin
                        w_op = DP_DEC;
                    end
                end
                ST_PAUSE: begin
                    if (w_go) begin
                        w_next_state = ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (w_go && !w_rld_is_zero) begin
                        w_op         = DP_RELOAD;
                        w_next_state = ST_RUN;
                    end
                end
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    assign state = r_state;
    assign tc    = r_tc;
    assign busy  = (r_state == ST_RUN) || (r_state == ST_PAUSE);

endmodule : downcounter_timer

// File: doc/downcounter_timer.md
DOWNCOUNTER_TIMER -- requirements
Module: downcounter_timer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the counter width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have port load, input, 1 bit, a level sampled each edge that loads load_val.
REQ-005 The block SHALL have port load_val, input, WIDTH bits, the count value to load.
REQ-006 The block SHALL have port start, input, 1 bit, which starts or resumes counting.
REQ-007 The block SHALL have port stop, input, 1 bit, which pauses counting.
REQ-008 The block SHALL have port auto_reload, input, 1 bit, a level selecting periodic mode.
REQ-009 The block SHALL have port q, output, WIDTH bits, the registered current count.
REQ-010 The block SHALL have port tc, output, 1 bit, a registered terminal-count pulse.
REQ-011 The block SHALL have port busy, output, 1 bit, high while in RUN or PAUSE.
REQ-012 The block SHALL have port state, output, 2 bits, the current FSM state.

Function
REQ-013 The FSM SHALL have states IDLE=0, RUN=1, PAUSE=2, DONE=3.
REQ-014 A reload register rld SHALL hold the most recently loaded value.
REQ-015 load SHALL take priority over all other inputs in every state: q<=load_val, rld<=load_val, state<=IDLE, tc<=0.
REQ-016 In IDLE, start with q!=0 SHALL go to RUN with q unchanged; start with q==0 SHALL be ignored.
REQ-017 In RUN, q SHALL decrement by 1 on each edge, starting one edge after the start edge.
REQ-018 In RUN with q==1 and auto_reload==0, the edge SHALL set q<=0, tc<=1 and state<=DONE.
REQ-019 In RUN with q==1, auto_reload==1 and rld!=0, the edge SHALL set q<=rld and tc<=1, and remain in RUN, giving a period of rld cycles.
REQ-020 In RUN with q==1, auto_reload==1 and rld==0, behaviour SHALL match REQ-018.
REQ-021 In RUN, stop SHALL move to PAUSE with q held, overriding any decrement or tc on that edge.
REQ-022 In PAUSE, q SHALL hold; start SHALL return to RUN; stop alone SHALL be ignored.
REQ-023 When start and stop are high together, stop SHALL win: RUN goes to PAUSE, and PAUSE and IDLE stay put.
REQ-024 In DONE, q SHALL hold 0; start with rld!=0 SHALL set q<=rld and go to RUN; start with rld==0 SHALL be ignored.
REQ-025 tc SHALL be high for exactly one cycle per terminal event and low otherwise.
REQ-026 busy SHALL be decoded directly from the state register, with no extra latency.
REQ-027 Decrement SHALL be modulo 2^WIDTH; underflow is unreachable by construction.

Reset
REQ-028 Asserting rst_n low SHALL immediately, without a clock edge, force q=0, rld=0, tc=0, state=IDLE and busy=0.
REQ-029 Reset asserted mid-operation SHALL abandon the count, with no tc emitted.
REQ-030 After rst_n deasserts, the block SHALL respond to inputs from the first rising clk edge.

Structure
REQ-031 State encodings and the WIDTH default SHALL live in a shared package, downcounter_pkg.
REQ-032 The datapath (q, rld, decrement/reload mux) SHALL be one sub-module, dc_datapath; the FSM and tc logic SHALL stay in the top level.

Verification (WIDTH=8)
REQ-033 Scenario: load 5, then start -> q=5,4,3,2,1,0 on successive edges; tc=1 only in the cycle with q=0; state=DONE; busy=0.
REQ-034 Scenario: auto_reload=1, load 3, start -> q=3,2,1,3,2,1,...; tc pulses every 3 cycles; busy remains 1.
REQ-035 Scenario: run from 8; stop when q=4, held 3 cycles; then start -> q stays 4 with busy=1 and state=PAUSE, then resumes 3,2,...
REQ-036 Scenario: load load_val=10 while in RUN at q=6 -> q=10, state=IDLE, tc=0; start then counts down from 10.
REQ-037 Scenario: pull rst_n low between edges while in RUN at q=7 -> q=0, state=IDLE, tc=0 before the next edge.
REQ-038 Scenario: start with q=0 in IDLE -> no change; start and stop together in RUN -> PAUSE; start in DONE after load 4 -> counts 4,3,2,1,0 again.
